// File: rtl/csa_serial_add_ctrl.sv
// Serial wide adder: one SLICE_W-bit carry-select slice is reused across
// NUM_SLICES operand slices, LSB first, with a registered inter-slice carry.
module csa_serial_add_ctrl #(
  parameter int unsigned SLICE_W    = 5,
  parameter int unsigned NUM_SLICES = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [SLICE_W*NUM_SLICES-1:0] i_add_term1,
  input  logic [SLICE_W*NUM_SLICES-1:0] i_add_term2,
  input  logic                          i_cin,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [SLICE_W*NUM_SLICES-1:0] o_sum,
  output logic                          o_cout,
  output logic                          o_busy
);

  localparam int unsigned W     = SLICE_W * NUM_SLICES;
  localparam int unsigned IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;

  logic [SLICE_W-1:0] slice_a, slice_b;
  logic [SLICE_W:0]   cand0, cand1, cand_sel;
  logic               last_slice;

  // Carry-select slice: both carry-in candidates, picked by the carry register
  always_comb begin
    slice_a    = a_q[idx_q*SLICE_W +: SLICE_W];
    slice_b    = b_q[idx_q*SLICE_W +: SLICE_W];
    cand0      = {1'b0, slice_a} + {1'b0, slice_b};
    cand1      = cand0 + (SLICE_W+1)'(1);
    cand_sel   = carry_q ? cand1 : cand0;
    last_slice = (idx_q == IDX_W'(NUM_SLICES - 1));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          a_d     = i_add_term1;
          b_d     = i_add_term2;
          carry_d = i_cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[idx_q*SLICE_W +: SLICE_W] = cand_sel[SLICE_W-1:0];
        carry_d                         = cand_sel[SLICE_W];
        idx_d                           = idx_q + IDX_W'(1);
        if (last_slice) begin
          cout_d  = cand_sel[SLICE_W];
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (i_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign o_ready = (state_q == S_IDLE);
  assign o_busy  = (state_q != S_IDLE);
  assign o_valid = (state_q == S_DONE);
  assign o_sum   = sum_q;
  assign o_cout  = cout_q;

endmodule

// File: tb/tb_csa_serial_add_ctrl.sv
// Bench for csa_serial_add_ctrl: vector table, corner-case sequences and a
// random back-to-back run, with results checked through a scoreboard queue.
module tb_csa_serial_add_ctrl;

  localparam int unsigned SLICE_W    = 5;
  localparam int unsigned NUM_SLICES = 4;
  localparam int unsigned W          = SLICE_W * NUM_SLICES;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         valid;
  logic         o_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         o_valid;
  logic         rdy_in;
  logic [W-1:0] o_sum;
  logic         o_cout;
  logic         o_busy;

  int   total;
  int   bad;
  int   cycle;
  res_t sb[$];
  res_t cur_exp;

  csa_serial_add_ctrl #(.SLICE_W(SLICE_W), .NUM_SLICES(NUM_SLICES)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (valid),
    .o_ready     (o_ready),
    .i_add_term1 (a),
    .i_add_term2 (b),
    .i_cin       (cin),
    .o_valid     (o_valid),
    .i_ready     (rdy_in),
    .o_sum       (o_sum),
    .o_cout      (o_cout),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cycle);
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    return '{sum: s[W-1:0], cout: s[W]};
  endfunction

  // One clock: handshakes seen before the edge drive the scoreboard after it
  task automatic tick(output bit acc, output bit dn);
    res_t got, e;
    acc = valid && o_ready && rst_n;
    dn  = o_valid && rdy_in && rst_n;
    got = '{sum: o_sum, cout: o_cout};
    @(posedge clk);
    #1;
    cycle++;
    if (acc) sb.push_back(cur_exp);
    if (dn) begin
      if (sb.size() == 0) begin
        fail_now("scoreboard_underflow");
      end else begin
        e = sb.pop_front();
        chk("sum", 32'(got.sum), 32'(e.sum));
        chk("cout", 32'(got.cout), 32'(e.cout));
      end
    end
  endtask

  task automatic tick1();
    bit acc, dn;
    tick(acc, dn);
  endtask

  task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input res_t e);
    bit acc, dn;
    int n;
    a = ta; b = tb_v; cin = tc; cur_exp = e; valid = 1'b1;
    n = 0;
    do begin
      tick(acc, dn);
      n++;
    end while (!acc && n < 20);
    if (!acc) fail_now("accept_timeout");
    valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_valid && lat < 20) begin
      tick1();
      lat++;
    end
    if (!o_valid) fail_now("valid_timeout");
  endtask

  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                    input logic tc, input res_t e);
    int lat;
    rdy_in = 1'b0;
    accept(ta, tb_v, tc, e);
    wait_valid(lat);
    chk("latency", 32'(lat), 32'(NUM_SLICES));
    rdy_in = 1'b1;
    tick1();
    chk("ready_after_done", 32'(o_ready), 32'd1);
    chk("valid_after_done", 32'(o_valid), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int   lat;
    int   accepts;
    int   last_acc;
    int   guard;
    bit   acc, dn;
    res_t r;
    logic [W-1:0] hold_sum;
    logic         hold_cout;

    vecs[0] = '{a: 20'h00001, b: 20'h00001, cin: 1'b0, exp_sum: 20'h00002, exp_cout: 1'b0};
    vecs[1] = '{a: 20'hFFFFF, b: 20'h00001, cin: 1'b0, exp_sum: 20'h00000, exp_cout: 1'b1};
    vecs[2] = '{a: 20'hFFFFF, b: 20'hFFFFF, cin: 1'b1, exp_sum: 20'hFFFFF, exp_cout: 1'b1};
    vecs[3] = '{a: 20'h12345, b: 20'h0ABCD, cin: 1'b0, exp_sum: 20'h1CF12, exp_cout: 1'b0};
    vecs[4] = '{a: 20'h80000, b: 20'h80000, cin: 1'b0, exp_sum: 20'h00000, exp_cout: 1'b1};
    vecs[5] = '{a: 20'h00000, b: 20'h00000, cin: 1'b1, exp_sum: 20'h00001, exp_cout: 1'b0};

    total = 0; bad = 0; cycle = 0;
    rst_n = 1'b0; valid = 1'b0; rdy_in = 1'b0; a = '0; b = '0; cin = 1'b0;
    cur_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy",  32'(o_busy),  32'd0);
    chk("rst_sum",   32'(o_sum),   32'd0);
    chk("rst_cout",  32'(o_cout),  32'd0);
    rst_n = 1'b1;
    tick1();

    foreach (vecs[i]) begin
      op(vecs[i].a, vecs[i].b, vecs[i].cin, '{sum: vecs[i].exp_sum, cout: vecs[i].exp_cout});
    end

    // Full ripple: carry register must read 1 after every slice
    rdy_in = 1'b0;
    accept(20'hFFFFF, 20'h00001, 1'b0, '{sum: 20'h00000, cout: 1'b1});
    chk("ripple_busy", 32'(o_busy), 32'd1);
    for (int k = 0; k < int'(NUM_SLICES); k++) begin
      tick1();
      chk("ripple_carry", 32'(dut.carry_q), 32'd1);
    end
    chk("ripple_valid", 32'(o_valid), 32'd1);

    // Backpressure while sitting in DONE
    hold_sum = o_sum; hold_cout = o_cout;
    for (int k = 0; k < 3; k++) begin
      valid = ~valid;
      a = $urandom(); b = $urandom(); cin = ~cin;
      tick1();
      chk("bp_valid", 32'(o_valid), 32'd1);
      chk("bp_ready", 32'(o_ready), 32'd0);
      chk("bp_sum",   32'(o_sum),   32'(hold_sum));
      chk("bp_cout",  32'(o_cout),  32'(hold_cout));
    end
    valid = 1'b1;
    rdy_in = 1'b1;
    tick1();
    chk("bp_release_ready", 32'(o_ready), 32'd1);
    chk("bp_release_busy",  32'(o_busy),  32'd0);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);
    valid = 1'b0;

    // Reset after two slices of a rippling add
    rdy_in = 1'b0;
    accept(20'hFFFFF, 20'h00001, 1'b0, '{sum: 20'h00000, cout: 1'b1});
    tick1();
    tick1();
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_ready", 32'(o_ready), 32'd1);
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_busy",  32'(o_busy),  32'd0);
    chk("midrst_sum",   32'(o_sum),   32'd0);
    chk("midrst_cout",  32'(o_cout),  32'd0);
    tick1();
    tick1();
    chk("rst_hold_valid", 32'(o_valid), 32'd0);
    rst_n = 1'b1;
    op(20'h00003, 20'h00004, 1'b0, '{sum: 20'h00007, cout: 1'b0});

    // Back-to-back random issue with both sides always ready
    rdy_in = 1'b1;
    a = W'($urandom()); b = W'($urandom()); cin = 1'($urandom_range(0, 1));
    cur_exp = model(a, b, cin);
    valid = 1'b1;
    accepts = 0; last_acc = -1; guard = 0;
    while (accepts < 1000 && guard < 8000) begin
      tick(acc, dn);
      guard++;
      if (acc) begin
        if (last_acc >= 0) chk("issue_period", 32'(cycle - last_acc), 32'(NUM_SLICES + 2));
        last_acc = cycle;
        accepts++;
        a = W'($urandom()); b = W'($urandom()); cin = 1'($urandom_range(0, 1));
        cur_exp = model(a, b, cin);
      end
    end
    if (accepts < 1000) fail_now("b2b_timeout");
    valid = 1'b0;
    wait_valid(lat);
    tick1();
    chk("b2b_drain", 32'(sb.size()), 32'd0);
    r = model(20'hFFFFF, 20'hFFFFF, 1'b1);
    chk("model_sanity_sum", 32'(r.sum), 32'h000FFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
